// File: rtl/key_event_counter.sv
// key_event_counter
//
// Counts debounced pushbutton presses on N_KEYS independent channels.
// Each raw key is synchronised, debounced over a DEB_CYCLES stability window,
// and converted into a one-cycle press pulse on the falling edge of the
// debounced level. Each pulse then moves that channel's counter up or down.
//
// Ports
//   iCLK        sole clock, rising edge
//   iRST        synchronous active-high reset
//   iKEY        raw asynchronous pushbuttons, active-low (0 = pressed)
//   iDOWN       count direction for all channels (0 = up, 1 = down)
//   iCLR        synchronous clear of all counters and overflow flags
//   iSEL        channel routed to oDIG
//   oKEY_PRESS  one-cycle debounced press pulses
//   oCOUNT      packed counters, channel i at [i*CNT_W +: CNT_W]
//   oOVF        sticky per-channel wrap/saturate flag
//   oDIG        selected counter zero-extended to six hex nibbles (registered)
module key_event_counter #(
  parameter int N_KEYS     = 4,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int SATURATE   = 0,
  localparam int SEL_W     = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [N_KEYS-1:0]         iKEY,
  input  logic                      iDOWN,
  input  logic                      iCLR,
  input  logic [SEL_W-1:0]          iSEL,
  output logic [N_KEYS-1:0]         oKEY_PRESS,
  output logic [N_KEYS*CNT_W-1:0]   oCOUNT,
  output logic [N_KEYS-1:0]         oOVF,
  output logic [23:0]               oDIG
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N_KEYS*CNT_W-1:0] count_all;
  logic [23:0]             dig_q;
  logic [23:0]             dig_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_d;
      logic             press_q;
      logic             press_d;
      logic             ovf_q;
      logic             ovf_d;
      logic [DEB_W-1:0] deb_q;
      logic [DEB_W-1:0] deb_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Debounce: the counter only runs while the synchronised input
      // disagrees with the accepted level; any agreement restarts the window.
      always_comb begin
        stable_d = stable_q;
        deb_d    = '0;
        if (sync2_q != stable_q) begin
          if (deb_q == DEB_LAST) begin
            stable_d = sync2_q;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        // Pulse is registered on the same edge the debounced level falls,
        // so it lines up with the stable transition rather than lagging it.
        press_d = stable_q & ~stable_d;
      end

      // Counter update happens the edge after the press pulse is visible.
      always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (press_q) begin
          if (!iDOWN) begin
            if (cnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
              cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (cnt_q == '0) begin
              ovf_d = 1'b1;
              cnt_d = (SATURATE != 0) ? cnt_q : CNT_MAX;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        // Clear wins over a coincident update; debounce path is untouched.
        if (iCLR) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end

      always_ff @(posedge iCLK) begin
        if (iRST) begin
          sync1_q  <= 1'b1;
          sync2_q  <= 1'b1;
          stable_q <= 1'b1;
          deb_q    <= '0;
          press_q  <= 1'b0;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end else begin
          sync1_q  <= iKEY[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          deb_q    <= deb_d;
          press_q  <= press_d;
          cnt_q    <= cnt_d;
          ovf_q    <= ovf_d;
        end
      end

      assign oKEY_PRESS[gi]                 = press_q;
      assign oOVF[gi]                       = ovf_q;
      assign count_all[gi*CNT_W +: CNT_W]   = cnt_q;
    end
  endgenerate

  assign oCOUNT = count_all;

  // Selected-channel display mux; an out-of-range select matches no channel
  // and therefore shows zero.
  always_comb begin
    dig_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (32'(iSEL) == 32'(i)) begin
        dig_d = 24'(count_all[i*CNT_W +: CNT_W]);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dig_q <= '0;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign oDIG = dig_q;

endmodule

// File: tb/tb_key_event_counter.sv
// Directed testbench for key_event_counter: one wrapping and one saturating
// instance share the same stimulus (N_KEYS=4, CNT_W=4, DEB_CYCLES=4).
module tb_key_event_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        down;
  logic        clr;
  logic [1:0]  sel;

  logic [3:0]  press_w, ovf_w, press_s, ovf_s;
  logic [15:0] count_w, count_s;
  logic [23:0] dig_w, dig_s;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};
  int base0, base3;

  always #5 clk = ~clk;

  key_event_counter #(.N_KEYS(4), .CNT_W(4), .DEB_CYCLES(4), .SATURATE(0)) dut_wrap (
    .iCLK(clk), .iRST(rst), .iKEY(key), .iDOWN(down), .iCLR(clr), .iSEL(sel),
    .oKEY_PRESS(press_w), .oCOUNT(count_w), .oOVF(ovf_w), .oDIG(dig_w)
  );

  key_event_counter #(.N_KEYS(4), .CNT_W(4), .DEB_CYCLES(4), .SATURATE(1)) dut_sat (
    .iCLK(clk), .iRST(rst), .iKEY(key), .iDOWN(down), .iCLR(clr), .iSEL(sel),
    .oKEY_PRESS(press_s), .oCOUNT(count_s), .oOVF(ovf_s), .oDIG(dig_s)
  );

  // Press pulses of the wrapping instance, counted away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (press_w[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    key = ~mask;
    step(8);
    key = 4'hF;
    step(8);
  endtask

  task automatic clear_all();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    key  = 4'hF;
    down = 1'b0;
    clr  = 1'b0;
    sel  = 2'd0;
    step(3);

    // Reset state
    chk("rst_count_w", 32'(count_w), 32'h0);
    chk("rst_count_s", 32'(count_s), 32'h0);
    chk("rst_ovf_w",   32'(ovf_w),   32'h0);
    chk("rst_press_w", 32'(press_w), 32'h0);
    chk("rst_dig_w",   32'(dig_w),   32'h0);
    rst = 1'b0;
    step(2);

    // Bounce: 3 low / 3 high is one short of the window, never accepted
    for (int c = 0; c < 30; c++) begin
      key[0] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    key = 4'hF;
    step(10);
    chk("bounce_pulses", 32'(pulse_cnt[0]), 32'd0);
    chk("bounce_count",  32'(count_w),      32'h0);

    // Clean press: sync1 samples the low level at edge E
    base0  = pulse_cnt[0];
    key[0] = 1'b0;
    step(1);                                   // edge E
    step(4);                                   // after E+4
    chk("clean_pre_pulse", 32'(press_w), 32'h0);
    step(1);                                   // after E+5
    chk("clean_pulse",     32'(press_w), 32'h1);
    step(1);                                   // after E+6
    chk("clean_pulse_end", 32'(press_w), 32'h0);
    chk("clean_count",     32'(count_w), 32'h0001);
    chk("clean_dig_lag",   32'(dig_w),   32'h0);
    step(1);                                   // after E+7
    chk("clean_dig",       32'(dig_w),   32'h000001);
    step(5);
    key = 4'hF;                                // release
    step(12);
    chk("clean_one_pulse", 32'(pulse_cnt[0] - base0), 32'd1);
    chk("clean_release",   32'(count_w), 32'h0001);

    // Wrap / saturate on channel 1
    for (int p = 0; p < 16; p++) press(4'b0010);
    chk("wrap16_count", 32'(count_w), 32'h0001);
    chk("wrap16_ovf",   32'(ovf_w),   32'h2);
    chk("sat16_count",  32'(count_s), 32'h00F1);
    chk("sat16_ovf",    32'(ovf_s),   32'h2);
    press(4'b0010);
    chk("wrap17_count", 32'(count_w), 32'h0011);
    chk("sat17_count",  32'(count_s), 32'h00F1);
    chk("sat17_ovf",    32'(ovf_s),   32'h2);
    sel = 2'd1;
    step(1);
    chk("dig_sel1_w", 32'(dig_w), 32'h000001);
    chk("dig_sel1_s", 32'(dig_s), 32'h00000F);
    sel = 2'd0;

    // Clear, then count down from zero on channel 2
    clear_all();
    chk("clr_count_w", 32'(count_w), 32'h0);
    chk("clr_ovf_s",   32'(ovf_s),   32'h0);
    down = 1'b1;
    press(4'b0100);
    down = 1'b0;
    chk("down_count_w", 32'(count_w), 32'h0F00);
    chk("down_ovf_w",   32'(ovf_w),   32'h4);
    chk("down_count_s", 32'(count_s), 32'h0000);
    chk("down_ovf_s",   32'(ovf_s),   32'h4);

    // All four keys together, clear coincident with the pending update
    key = 4'h0;
    step(1);                                   // edge E
    step(5);                                   // after E+5
    chk("all_pulse", 32'(press_w), 32'hF);
    clr = 1'b1;
    step(1);                                   // edge E+6: update and clear
    clr = 1'b0;
    chk("clr_win_count_w", 32'(count_w), 32'h0);
    chk("clr_win_ovf_w",   32'(ovf_w),   32'h0);
    chk("clr_win_count_s", 32'(count_s), 32'h0);
    step(4);
    key = 4'hF;
    step(12);
    press(4'hF);
    chk("all_count_w", 32'(count_w), 32'h1111);
    chk("all_count_s", 32'(count_s), 32'h1111);
    chk("all_ovf_w",   32'(ovf_w),   32'h0);

    // Reset during a channel-3 debounce, key held low through release
    base3  = pulse_cnt[3];
    key[3] = 1'b0;
    step(1);                                   // edge E
    step(3);                                   // after E+3: debounce count 2
    rst = 1'b1;
    step(1);                                   // reset edge
    rst = 1'b0;
    chk("rst_mid_press", 32'(press_w), 32'h0);
    chk("rst_mid_count", 32'(count_w), 32'h0);
    step(1);                                   // first post-reset edge F
    step(4);                                   // after F+4
    chk("rst_rel_pre", 32'(press_w), 32'h0);
    step(1);                                   // after F+5
    chk("rst_rel_pulse", 32'(press_w), 32'h8);
    step(1);                                   // after F+6
    chk("rst_rel_count", 32'(count_w), 32'h1000);
    key = 4'hF;
    step(10);
    chk("rst_one_pulse", 32'(pulse_cnt[3] - base3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
